pva_setpoint_integrator: RTL



---
 rtl/pva_setpoint_integrator.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pva_setpoint_integrator.sv
// Captures per-axis PVA frames from actuator_pva and, on each control tick, emits a
// six-axis setpoint stream that is either freshly loaded or semi-implicitly integrated.
module pva_setpoint_integrator #(
  parameter int INS_WIDTH     = 32,
  parameter int TICK_DIV      = 125000,
  parameter int TIMEOUT_TICKS = 50
) (
  input  logic                 gmii_rx_clk,
  input  logic                 reset_n,
  input  logic                 i_act_pva_axis_data_en,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_A_pos_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_A_vel_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_A_acc_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_B_pos_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_B_vel_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_B_acc_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_C_pos_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_C_vel_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_C_acc_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_D_pos_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_D_vel_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_D_acc_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_E_pos_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_E_vel_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_E_acc_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_F_pos_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_F_vel_data,
  input  logic [INS_WIDTH-1:0] i_act_pva_axis_F_acc_data,
  output logic                 o_sp_valid,
  output logic [2:0]           o_sp_axis,
  output logic [INS_WIDTH-1:0] o_sp_pos,
  output logic [INS_WIDTH-1:0] o_sp_vel,
  output logic                 o_sp_sat,
  output logic                 o_stale,
  output logic                 o_busy
);

  localparam int unsigned NUM_AXES = 6;
  localparam int unsigned CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MISS_W   = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [CNT_W-1:0]     TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [MISS_W-1:0]    MISS_MAX  = MISS_W'(TIMEOUT_TICKS);
  localparam logic [2:0]           LAST_AXIS = 3'(NUM_AXES - 1);
  localparam logic [INS_WIDTH-1:0] POS_MAX   = {1'b0, {(INS_WIDTH-1){1'b1}}};
  localparam logic [INS_WIDTH-1:0] NEG_MAX   = {1'b1, {(INS_WIDTH-1){1'b0}}};

  typedef logic [INS_WIDTH-1:0] word_t;
  typedef enum logic {ST_IDLE, ST_STEP} state_t;

  state_t            state, state_nx;
  logic [2:0]        step_idx, step_idx_nx;
  logic [CNT_W-1:0]  tick_cnt;
  logic              tick;

  word_t in_pos [NUM_AXES];
  word_t in_vel [NUM_AXES];
  word_t in_acc [NUM_AXES];
  word_t shadow_pos [NUM_AXES];
  word_t shadow_vel [NUM_AXES];
  word_t shadow_acc [NUM_AXES];
  word_t work_pos [NUM_AXES];
  word_t work_vel [NUM_AXES];
  word_t work_acc [NUM_AXES];
  word_t work_pos_nx [NUM_AXES];
  word_t work_vel_nx [NUM_AXES];
  word_t work_acc_nx [NUM_AXES];

  logic              new_frame, new_frame_nx;
  logic              load_mode, load_mode_nx;
  logic [MISS_W-1:0] missed, missed_nx, missed_inc;
  logic              stale_nx;

  logic              proc_en, proc_load;
  logic [2:0]        proc_axis;
  word_t             src_pos, src_vel, src_acc;
  word_t             vel_int, pos_int;
  logic              vel_clamp, pos_clamp;
  word_t             res_pos, res_vel;
  logic              res_sat;

  function automatic word_t sat_add(input word_t a, input word_t b, output logic clamped);
    logic [INS_WIDTH:0] sum;
    sum     = {a[INS_WIDTH-1], a} + {b[INS_WIDTH-1], b};
    clamped = 1'b0;
    sat_add = sum[INS_WIDTH-1:0];
    if (sum[INS_WIDTH] != sum[INS_WIDTH-1]) begin
      clamped = 1'b1;
      sat_add = sum[INS_WIDTH] ? NEG_MAX : POS_MAX;
    end
  endfunction

  always_comb begin
    in_pos[0] = i_act_pva_axis_A_pos_data;
    in_vel[0] = i_act_pva_axis_A_vel_data;
    in_acc[0] = i_act_pva_axis_A_acc_data;
    in_pos[1] = i_act_pva_axis_B_pos_data;
    in_vel[1] = i_act_pva_axis_B_vel_data;
    in_acc[1] = i_act_pva_axis_B_acc_data;
    in_pos[2] = i_act_pva_axis_C_pos_data;
    in_vel[2] = i_act_pva_axis_C_vel_data;
    in_acc[2] = i_act_pva_axis_C_acc_data;
    in_pos[3] = i_act_pva_axis_D_pos_data;
    in_vel[3] = i_act_pva_axis_D_vel_data;
    in_acc[3] = i_act_pva_axis_D_acc_data;
    in_pos[4] = i_act_pva_axis_E_pos_data;
    in_vel[4] = i_act_pva_axis_E_vel_data;
    in_acc[4] = i_act_pva_axis_E_acc_data;
    in_pos[5] = i_act_pva_axis_F_pos_data;
    in_vel[5] = i_act_pva_axis_F_vel_data;
    in_acc[5] = i_act_pva_axis_F_acc_data;
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_comb begin
    state_nx    = state;
    step_idx_nx = step_idx;
    case (state)
      ST_IDLE: begin
        if (tick) begin
          state_nx    = ST_STEP;
          step_idx_nx = '0;
        end
      end
      ST_STEP: begin
        if (step_idx == LAST_AXIS) begin
          state_nx    = ST_IDLE;
          step_idx_nx = '0;
        end else begin
          step_idx_nx = step_idx + 3'd1;
        end
      end
      default: begin
        state_nx    = ST_IDLE;
        step_idx_nx = '0;
      end
    endcase
  end

  // The datapath runs one axis ahead of the STEP index so registered outputs line up
  // with o_busy: the tick cycle processes axis 0, STEP index k processes axis k+1.
  always_comb begin
    proc_en   = tick || ((state == ST_STEP) && (step_idx != LAST_AXIS));
    proc_axis = tick ? 3'd0 : step_idx + 3'd1;
    proc_load = tick ? new_frame : load_mode;
  end

  always_comb begin
    work_pos_nx  = work_pos;
    work_vel_nx  = work_vel;
    work_acc_nx  = work_acc;
    missed_nx    = missed;
    stale_nx     = o_stale;
    load_mode_nx = load_mode;
    new_frame_nx = new_frame;
    missed_inc   = (missed == MISS_MAX) ? missed : missed + MISS_W'(1);

    if (tick) begin
      new_frame_nx = 1'b0;
      load_mode_nx = new_frame;
      if (new_frame) begin
        work_pos_nx = shadow_pos;
        work_vel_nx = shadow_vel;
        work_acc_nx = shadow_acc;
        missed_nx   = '0;
        stale_nx    = 1'b0;
      end else begin
        missed_nx = missed_inc;
        if (missed_inc == MISS_MAX) begin
          stale_nx = 1'b1;
          for (int unsigned i = 0; i < NUM_AXES; i++) begin
            work_vel_nx[i] = '0;
            work_acc_nx[i] = '0;
          end
        end
      end
    end
    if (i_act_pva_axis_data_en) begin
      new_frame_nx = 1'b1;
    end

    // Sources are taken after the tick load/zeroing so axis 0 sees the fresh set.
    src_pos = work_pos_nx[proc_axis];
    src_vel = work_vel_nx[proc_axis];
    src_acc = work_acc_nx[proc_axis];
    vel_int = sat_add(src_vel, src_acc, vel_clamp);
    pos_int = sat_add(src_pos, vel_int, pos_clamp);

    res_pos = src_pos;
    res_vel = src_vel;
    res_sat = 1'b0;
    if (!proc_load) begin
      res_pos = pos_int;
      res_vel = vel_int;
      res_sat = vel_clamp | pos_clamp;
    end
    if (proc_en && !proc_load) begin
      work_pos_nx[proc_axis] = pos_int;
      work_vel_nx[proc_axis] = vel_int;
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      step_idx <= '0;
    end else begin
      state    <= state_nx;
      step_idx <= step_idx_nx;
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!reset_n) begin
      tick_cnt  <= '0;
      new_frame <= 1'b0;
      load_mode <= 1'b0;
      missed    <= '0;
      for (int unsigned i = 0; i < NUM_AXES; i++) begin
        shadow_pos[i] <= '0;
        shadow_vel[i] <= '0;
        shadow_acc[i] <= '0;
        work_pos[i]   <= '0;
        work_vel[i]   <= '0;
        work_acc[i]   <= '0;
      end
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + CNT_W'(1);
      new_frame <= new_frame_nx;
      load_mode <= load_mode_nx;
      missed    <= missed_nx;
      work_pos  <= work_pos_nx;
      work_vel  <= work_vel_nx;
      work_acc  <= work_acc_nx;
      if (i_act_pva_axis_data_en) begin
        shadow_pos <= in_pos;
        shadow_vel <= in_vel;
        shadow_acc <= in_acc;
      end
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (!reset_n) begin
      o_sp_valid <= 1'b0;
      o_sp_axis  <= '0;
      o_sp_pos   <= '0;
      o_sp_vel   <= '0;
      o_sp_sat   <= 1'b0;
      o_stale    <= 1'b1;
      o_busy     <= 1'b0;
    end else begin
      o_sp_valid <= proc_en;
      o_stale    <= stale_nx;
      o_busy     <= (state_nx == ST_STEP);
      if (proc_en) begin
        o_sp_axis <= proc_axis;
        o_sp_pos  <= res_pos;
        o_sp_vel  <= res_vel;
        o_sp_sat  <= res_sat;
      end
    end
  end

endmodule
